apb_slave_mem: RTL

- APB3 completer (slave) that sits directly downstream of the APB interface's master-side signals.
- Consumes PSEL1/PENABLE/PADDR/PWRITE/PWDATA and produces PRDATA/PREADY/PSLVERR.
- Backs a word-addressed register memory and inserts a configurable number of wait states per transfer.
- Flags out-of-range or misaligned accesses with PSLVERR.

---
 rtl/apb_pkg.sv | 10 +
 rtl/apb_slave_mem_if.sv | 31 +++
 rtl/apb_wait_ctr.sv | 19 +
 rtl/apb_slave_mem.sv | 79 +++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type, bus defaults and byte-offset helper for the APB completer.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_MAX_WAIT = 15;
  function automatic int off_bits(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB3 bus bundle; PSTRB exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_mem_if import apb_pkg::*; #(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W
);
  logic                    PSEL1;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SLV_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  modport slave (
`ifdef APB_SLV_PSTRB_EN
    input PSTRB,
`endif
    input PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
  modport master (
`ifdef APB_SLV_PSTRB_EN
    output PSTRB,
`endif
    output PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
    input PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: 4-bit loadable wait-state down-counter; clear beats load beats decrement.
module apb_wait_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? 4'd0 : load ? load_val : (en && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    zero = cnt_q == 4'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer backed by a word memory with WAIT_STATES wait cycles and PSLVERR decode.
// Define APB_SLV_PSTRB_EN to add PSTRB byte-lane write strobes.
module apb_slave_mem import apb_pkg::*; #(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            PRESET,
  apb_slave_mem_if.slave  bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF = off_bits(DATA_WIDTH);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * NB);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  apb_state_e state_q, state_d, cur;
  logic [IW-1:0] idx_q, idx_d;
  logic pwrite_q, pwrite_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NB-1:0] strb_q, strb_d;
  logic [ADDR_WIDTH-1:0] off;
  logic zero, setup, abort, done, commit;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  apb_wait_ctr u_ctr (
    .clk(clk), .rst(PRESET), .load(setup), .en(cur == ACCESS), .clr(abort),
    .load_val(WS), .zero(zero)
  );
  // SETUP is the bus setup-phase cycle itself, so the latch edge that ends it can enter ACCESS
  // and a zero-wait transfer completes in the first PENABLE cycle.
  always_comb begin
    off = bus.PADDR - BASE_ADDR;
    cur = state_q == ACCESS ? ACCESS : (bus.PSEL1 && !bus.PENABLE) ? SETUP : IDLE;
    setup = cur == SETUP;
    abort = cur == ACCESS && !(bus.PSEL1 && bus.PENABLE);
    done = cur == ACCESS && zero;
    commit = done && !abort && pwrite_q && !err_q;
    state_d = setup ? ACCESS : (abort || done) ? IDLE : state_q;
    idx_d = setup ? off[OFF +: IW] : idx_q;
    pwrite_d = setup ? bus.PWRITE : pwrite_q;
    wdata_d = setup ? bus.PWDATA : wdata_q;
    err_d = setup ? (bus.PADDR < BASE_ADDR || {1'b0, off} >= MEM_BYTES ||
                     (bus.PADDR & ADDR_WIDTH'(NB - 1)) != '0) : err_q;
`ifdef APB_SLV_PSTRB_EN
    strb_d = setup ? bus.PSTRB : strb_q;
`else
    strb_d = '1;
`endif
    rdata_d = (done && !pwrite_q) ? (err_q ? '0 : mem_q[idx_q]) : rdata_q;
    bus.PRDATA = (done && err_q) ? '0 : rdata_d;
    bus.PREADY = done;
    bus.PSLVERR = done && err_q;
  end
  always_ff @(posedge clk or posedge PRESET)
    if (PRESET) begin
      state_q <= IDLE;
      idx_q <= '0;
      pwrite_q <= 1'b0;
      err_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pwrite_q <= pwrite_d;
      err_q <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      strb_q <= strb_d;
    end
  always_ff @(posedge clk or posedge PRESET)
    if (PRESET) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (commit)
      for (int b = 0; b < NB; b++)
        if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
endmodule
